// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/flush controller: per-stage stall/flush vectors, PC redirect,
// multi-cycle EX hold FSM and a saturating mispredict counter.
module pipe_hazard_ctrl #(
  parameter int STAGES = 5,
  parameter int EX_IDX = 3,
  parameter int AW     = 32,
  parameter int MC_W   = 6,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [STAGES-1:0] stall_req_i,
  input  logic              prd_jump_en_i,
  input  logic              id_ex_jump_en_i,
  input  logic              ex_jump_en_i,
  input  logic [AW-1:0]     ex_jump_addr_i,
  input  logic [AW-1:0]     ex_pc_i,
  input  logic              mc_start_i,
  input  logic [MC_W-1:0]   mc_cycles_i,
  input  logic              excp_req_i,
  input  logic [AW-1:0]     excp_addr_i,
  input  logic              cnt_clr_i,
  output logic [STAGES-1:0] stall_o,
  output logic [STAGES-1:0] flush_o,
  output logic              redirect_en_o,
  output logic [AW-1:0]     redirect_addr_o,
  output logic              prd_fail_o,
  output logic              mc_busy_o,
  output logic              mc_done_o,
  output logic [CNT_W-1:0]  mispredict_cnt_o
);

  localparam logic [0:0] StIdle   = 1'b0;
  localparam logic [0:0] StMcHold = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [MC_W-1:0]   mc_cnt_q, mc_cnt_d;
  logic [CNT_W-1:0]  mp_cnt_q, mp_cnt_d;

  logic              prd_fail;
  logic [STAGES-1:0] stall_c, flush_c;
  logic              redirect_en_c;
  logic [AW-1:0]     redirect_addr_c;
  logic              mc_done_c;

  assign prd_fail = (state_q == StIdle) && (ex_jump_en_i != id_ex_jump_en_i);

  always_comb begin
    int hi;
    stall_c         = '0;
    flush_c         = '0;
    redirect_en_c   = 1'b0;
    redirect_addr_c = '0;
    mc_done_c       = 1'b0;
    hi              = -1;
    for (int i = 0; i < STAGES; i++) begin
      if (stall_req_i[i]) hi = i;
    end

    if (excp_req_i) begin
      for (int i = 0; i < STAGES; i++) flush_c[i] = (i <= EX_IDX);
      redirect_en_c   = 1'b1;
      redirect_addr_c = excp_addr_i;
    end else if (state_q == StMcHold) begin
      for (int i = 0; i < STAGES; i++) begin
        stall_c[i] = (i <= EX_IDX);
        flush_c[i] = (i == EX_IDX + 1);
      end
      mc_done_c = (mc_cnt_q == MC_W'(1));
    end else if (prd_fail) begin
      for (int i = 0; i < STAGES; i++) flush_c[i] = (i < EX_IDX);
      redirect_en_c   = 1'b1;
      redirect_addr_c = ex_jump_en_i ? ex_jump_addr_i : ex_pc_i + AW'(4);
    end else if (hi >= 0) begin
      for (int i = 0; i < STAGES; i++) begin
        stall_c[i] = (i <= hi);
        flush_c[i] = (i == hi + 1);
      end
    end else if (prd_jump_en_i) begin
      // Only IF/ID gets the bubble; ID/EX advances so EX can verify the guess.
      flush_c[1] = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    mc_cnt_d = mc_cnt_q;
    case (state_q)
      StIdle: begin
        if (mc_start_i && (mc_cycles_i != '0) && !excp_req_i && !prd_fail) begin
          state_d  = StMcHold;
          mc_cnt_d = mc_cycles_i;
        end
      end
      StMcHold: begin
        if (excp_req_i) begin
          state_d  = StIdle;
          mc_cnt_d = '0;
        end else begin
          mc_cnt_d = mc_cnt_q - MC_W'(1);
          if (mc_cnt_q == MC_W'(1)) state_d = StIdle;
        end
      end
      default: begin
        state_d  = StIdle;
        mc_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    mp_cnt_d = mp_cnt_q;
    if (cnt_clr_i) begin
      mp_cnt_d = '0;
    end else if (prd_fail && !excp_req_i && (mp_cnt_q != '1)) begin
      mp_cnt_d = mp_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= StIdle;
      mc_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      mc_cnt_q <= mc_cnt_d;
      mp_cnt_q <= mp_cnt_d;
    end
  end

  // Outputs are forced low for the whole time reset is held.
  assign stall_o          = rstn ? stall_c : '0;
  assign flush_o          = rstn ? flush_c : '0;
  assign redirect_en_o    = rstn & redirect_en_c;
  assign redirect_addr_o  = rstn ? redirect_addr_c : '0;
  assign prd_fail_o       = rstn & prd_fail;
  assign mc_busy_o        = rstn & (state_q == StMcHold);
  assign mc_done_o        = rstn & mc_done_c;
  assign mispredict_cnt_o = rstn ? mp_cnt_q : '0;

endmodule
